clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time controller for the oscillator clock divider of the PT2262/PT2272 enc/dec.
//  Owns the divide ratio and the run/stop sequencing, and generates the divided clock.
//  Ratio changes and stops happen only at glitch-free boundaries.
//  Also emits single-cycle edge ticks for the encoder/decoder bit-timing logic.
// PARAMETERS
//  CNT_W         16   width of the half-period counter and of CFG_HALF
//  DEFAULT_HALF  125  half-period (in INPUT_CLK cycles) loaded at reset
// PORTS
//  INPUT_CLK   in   1      sole clock; all logic on its rising edge
//  RST         in   1      asynchronous, active-high reset
//  EN          in   1      level: 1 = run divided clock, 0 = stop (glitch-free)
//  CFG_VALID   in   1      new half-period offered
//  CFG_HALF    in   CNT_W  requested half-period; must be >= 1
//  CFG_READY   out  1      shadow register empty; handshake = CFG_VALID & CFG_READY
//  CFG_ERR     out  1      1-cycle pulse: accepted CFG_HALF==0 was discarded
//  OUTPUT_CLK  out  1      divided clock, period 2*half INPUT_CLK cycles
//  TICK_RISE   out  1      1-cycle pulse, high in the first cycle OUTPUT_CLK is 1
//  TICK_FALL   out  1      1-cycle pulse, high in the first cycle OUTPUT_CLK is 0 after a high phase
//  BUSY        out  1      state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, cnt=0, active_half=DEFAULT_HALF, shadow empty.
//   - OUTPUT_CLK=0, TICK_*=0, CFG_ERR=0, CFG_READY=1, BUSY=0.
//   - RST mid-operation: everything returns to these values asynchronously; any pending config is lost.
//  FSM {IDLE, RUN, STOP}:
//   - IDLE: OUTPUT_CLK=0, cnt=0. EN=1 -> RUN with cnt<=1.
//   - RUN: if cnt<active_half then cnt++, else cnt<=1 and OUTPUT_CLK toggles.
//     - First rise comes active_half cycles after the RUN-entry edge.
//     - EN=0 with OUTPUT_CLK=0 -> IDLE next edge.
//     - EN=0 with OUTPUT_CLK=1 -> STOP.
//   - STOP: counts exactly as RUN.
//     - On the falling toggle (1->0) -> IDLE.
//     - EN=1 again before that toggle -> RUN with no counter disturbance.
//  Config:
//   - Accept on CFG_VALID&CFG_READY; the value goes into the shadow and CFG_READY drops.
//   - CFG_HALF==0: discarded, shadow unchanged, CFG_ERR pulses the next cycle.
//   - In IDLE, shadow -> active_half on the next edge.
//   - In RUN/STOP, shadow is applied only on the edge performing a falling toggle; cnt<=1 there.
//   - Config accepted on the same edge as a falling toggle waits for the next falling toggle.
//   - CFG_READY returns 1 the cycle after the shadow is applied.
//  Arithmetic:
//   - cnt and active_half are unsigned CNT_W; compare is <, no wrap possible.
//   - CFG_HALF=1 gives /2: OUTPUT_CLK toggles every edge.
//  Ticks are registered together with OUTPUT_CLK (0 latency relative to the edge).
//  TICK_FALL is suppressed when entering IDLE from reset.
// STRUCTURE
//  Package clk_div_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, STOP} clk_div_state_t
//   - localparams CNT_W_DEF=16, HALF_DEF=125
//  Sub-module clk_div_core:
//   - cnt/toggle datapath with ports load, half, en_count; produces OUTPUT_CLK, rise, fall.
//   - clk_div_ctrl holds the FSM, the shadow/handshake and the tick registers.
// TESTING
//  1. Reset, EN=1, default half=125 -> first rise 125 cycles after RUN entry; period 250; one TICK_RISE and one TICK_FALL per period.
//  2. IDLE, push CFG_HALF=3 then EN=1 -> OUTPUT_CLK 3 high / 3 low; CFG_READY low for exactly 1 cycle.
//  3. RUN at half=5, push CFG_HALF=2 mid high phase -> high phase completes at 5; low phases are 2; CFG_READY low until the fall edge.
//  4. RUN, drop EN while OUTPUT_CLK=1 -> high phase finishes full length, then IDLE, BUSY=0; re-assert EN in STOP -> no gap in the waveform.
//  5. Push CFG_HALF=0 -> CFG_ERR 1-cycle pulse; active_half unchanged; CFG_READY stays 1.
//  6. Assert RST mid high phase with a pending config -> OUTPUT_CLK=0 immediately; after release the next run uses half=125.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the oscillator clock divider controller.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned HALF_DEF  = 125;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } clk_div_state_t;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and toggle flop; reports the edge that toggles the divided clock.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             INPUT_CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             en_count,
  input  logic [CNT_W-1:0] half,
  output logic             OUTPUT_CLK,
  output logic             rise_c,
  output logic             fall_c
);

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c = en_count && !(cnt < half);
  assign rise_c = wrap_c && !OUTPUT_CLK;
  assign fall_c = wrap_c && OUTPUT_CLK;

  // When not counting the divider is parked low; load primes cnt for RUN entry.
  always_ff @(posedge INPUT_CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      OUTPUT_CLK <= 1'b0;
    end else if (en_count) begin
      if (wrap_c) begin
        cnt        <= CNT_W'(1);
        OUTPUT_CLK <= !OUTPUT_CLK;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt        <= load ? CNT_W'(1) : '0;
      OUTPUT_CLK <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop sequencing, ratio shadow handshake and edge ticks around the divider core.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = HALF_DEF
) (
  input  logic             INPUT_CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CFG_VALID,
  input  logic [CNT_W-1:0] CFG_HALF,
  output logic             CFG_READY,
  output logic             CFG_ERR,
  output logic             OUTPUT_CLK,
  output logic             TICK_RISE,
  output logic             TICK_FALL,
  output logic             BUSY
);

  clk_div_state_t   state, next_state;
  logic [CNT_W-1:0] active_half;
  logic [CNT_W-1:0] shadow;
  logic             load, en_count;
  logic             rise_c, fall_c;
  logic             accept_c, apply_c;

  // CFG_READY low means the shadow holds a value waiting for a safe boundary.
  assign accept_c = CFG_VALID && CFG_READY;
  assign apply_c  = !CFG_READY && ((state == IDLE) || fall_c);

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .INPUT_CLK (INPUT_CLK),
    .RST       (RST),
    .load      (load),
    .en_count  (en_count),
    .half      (active_half),
    .OUTPUT_CLK(OUTPUT_CLK),
    .rise_c    (rise_c),
    .fall_c    (fall_c)
  );

  always_ff @(posedge INPUT_CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Stop only ever completes on a low level: a high phase always runs to its fall.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (EN) next_state = RUN;
      RUN: begin
        if (!EN) begin
          if (!OUTPUT_CLK || fall_c) next_state = IDLE;
          else                       next_state = STOP;
        end
      end
      STOP: begin
        if (EN)          next_state = RUN;
        else if (fall_c) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    en_count = 1'b0;
    case (state)
      IDLE:    load     = EN;
      RUN:     en_count = EN || OUTPUT_CLK;
      STOP:    en_count = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge INPUT_CLK or posedge RST) begin
    if (RST) begin
      active_half <= CNT_W'(DEFAULT_HALF);
      shadow      <= '0;
      CFG_READY   <= 1'b1;
      CFG_ERR     <= 1'b0;
      TICK_RISE   <= 1'b0;
      TICK_FALL   <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      CFG_ERR   <= accept_c && (CFG_HALF == '0);
      TICK_RISE <= rise_c;
      TICK_FALL <= fall_c;
      BUSY      <= (next_state != IDLE);
      if (apply_c) begin
        active_half <= shadow;
        CFG_READY   <= 1'b1;
      end else if (accept_c && (CFG_HALF != '0)) begin
        shadow    <= CFG_HALF;
        CFG_READY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed plus randomized checks of clk_div_ctrl against a phase-length reference model.
module tb_clk_div_ctrl;

  localparam int unsigned W = 16;

  logic         INPUT_CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic         CFG_VALID;
  logic [W-1:0] CFG_HALF;
  logic         CFG_READY, CFG_ERR, OUTPUT_CLK, TICK_RISE, TICK_FALL, BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase length bookkeeping in edges remaining
  bit m_busy, m_clk, m_rise, m_fall, m_err, m_full;
  int m_half, m_shadow, m_left;

  always #5 INPUT_CLK = ~INPUT_CLK;

  clk_div_ctrl dut (
    .INPUT_CLK (INPUT_CLK),
    .RST       (RST),
    .EN        (EN),
    .CFG_VALID (CFG_VALID),
    .CFG_HALF  (CFG_HALF),
    .CFG_READY (CFG_READY),
    .CFG_ERR   (CFG_ERR),
    .OUTPUT_CLK(OUTPUT_CLK),
    .TICK_RISE (TICK_RISE),
    .TICK_FALL (TICK_FALL),
    .BUSY      (BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_clk = 0; m_rise = 0; m_fall = 0; m_err = 0; m_full = 0;
    m_half = 125; m_shadow = 0; m_left = 0;
  endtask

  task automatic model_edge(input bit en, input bit v, input int h);
    bit acc;
    acc    = v && !m_full;
    m_rise = 0;
    m_fall = 0;
    m_err  = acc && (h == 0);
    if (!m_busy) begin
      if (m_full) begin m_half = m_shadow; m_full = 0; end
      if (en) begin m_busy = 1; m_left = m_half; end
    end else if (!en && !m_clk) begin
      m_busy = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_clk  = !m_clk;
        m_left = m_half;
        if (m_clk) m_rise = 1;
        else begin
          m_fall = 1;
          if (m_full) begin m_half = m_shadow; m_full = 0; m_left = m_half; end
          if (!en) m_busy = 0;
        end
      end
    end
    if (acc && (h != 0)) begin m_shadow = h; m_full = 1; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_clk"},   32'(OUTPUT_CLK), 32'(m_clk));
    chk({tag, "_rise"},  32'(TICK_RISE),  32'(m_rise));
    chk({tag, "_fall"},  32'(TICK_FALL),  32'(m_fall));
    chk({tag, "_busy"},  32'(BUSY),       32'(m_busy));
    chk({tag, "_ready"}, 32'(CFG_READY),  32'(!m_full));
    chk({tag, "_err"},   32'(CFG_ERR),    32'(m_err));
  endtask

  task automatic step();
    @(posedge INPUT_CLK);
    model_edge(EN, CFG_VALID, int'(CFG_HALF));
    #1;
    check_all("cyc");
    @(negedge INPUT_CLK);
  endtask

  task automatic push(input int h);
    CFG_VALID = 1'b1;
    CFG_HALF  = W'(h);
    step();
    CFG_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge INPUT_CLK);
    RST = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    while (OUTPUT_CLK !== lvl && n < 2000) begin
      step();
      n++;
    end
    chk("wait_level_bound", 32'(n < 2000), 32'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 2000) begin
      step();
      n++;
    end
    chk("wait_idle_bound", 32'(n < 2000), 32'(1));
  endtask

  initial begin
    int n, n2;
    RST = 1'b1; EN = 1'b0; CFG_VALID = 1'b0; CFG_HALF = '0;
    @(negedge INPUT_CLK);
    do_reset();

    // Default ratio: first rise 125 edges after entry, period 250
    EN = 1'b1;
    step();
    wait_level(1'b1, n);
    chk("t1_first_rise", 32'(n), 32'd125);
    wait_level(1'b0, n);
    wait_level(1'b1, n2);
    chk("t1_period", 32'(n + n2), 32'd250);
    EN = 1'b0;
    wait_idle();

    // Config in IDLE takes effect at once
    push(3);
    chk("t2_ready_low", 32'(CFG_READY), 32'd0);
    EN = 1'b1;
    step();
    chk("t2_ready_back", 32'(CFG_READY), 32'd1);
    wait_level(1'b1, n);
    wait_level(1'b0, n);
    chk("t2_high", 32'(n), 32'd3);
    wait_level(1'b1, n);
    chk("t2_low", 32'(n), 32'd3);

    // Change mid high phase: old half completes, new half from the fall
    EN = 1'b0;
    wait_idle();
    push(5);
    EN = 1'b1;
    step();
    wait_level(1'b1, n);
    step();
    step();
    push(2);
    chk("t3_ready_pending", 32'(CFG_READY), 32'd0);
    wait_level(1'b0, n);
    chk("t3_high_old", 32'(n + 3), 32'd5);
    chk("t3_ready_after_fall", 32'(CFG_READY), 32'd1);
    wait_level(1'b1, n);
    chk("t3_low_new", 32'(n), 32'd2);
    wait_level(1'b0, n);
    chk("t3_high_new", 32'(n), 32'd2);

    // Stop during high phase finishes it; re-enable in STOP leaves no gap
    push(4);
    wait_level(1'b1, n);
    wait_level(1'b0, n);
    wait_level(1'b1, n);
    step();
    EN = 1'b0;
    wait_level(1'b0, n);
    chk("t4_stop_high", 32'(n + 1), 32'd4);
    chk("t4_idle", 32'(BUSY), 32'd0);
    EN = 1'b1;
    step();
    wait_level(1'b1, n);
    step();
    EN = 1'b0;
    step();
    step();
    EN = 1'b1;
    wait_level(1'b0, n);
    chk("t4_resume_high", 32'(n + 3), 32'd4);
    wait_level(1'b1, n);
    chk("t4_resume_low", 32'(n), 32'd4);

    // Zero half is rejected
    push(0);
    chk("t5_err", 32'(CFG_ERR), 32'd1);
    chk("t5_ready", 32'(CFG_READY), 32'd1);
    step();
    chk("t5_err_clear", 32'(CFG_ERR), 32'd0);
    wait_level(1'b0, n);
    wait_level(1'b1, n);
    chk("t5_half_kept", 32'(n), 32'd4);

    // Reset mid high phase with pending config
    step();
    push(7);
    do_reset();
    chk("t6_clk_low", 32'(OUTPUT_CLK), 32'd0);
    step();
    wait_level(1'b1, n);
    chk("t6_default_half", 32'(n), 32'd125);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) EN = !EN;
      CFG_VALID = ($urandom_range(0, 7) == 0);
      CFG_HALF  = W'($urandom_range(0, 6));
      if ($urandom_range(0, 699) == 0) do_reset();
      else step();
    end
    CFG_VALID = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
